// File: rtl/mandelbrot_pkg.sv
// ============================================================================
// Module      : mandelbrot_pkg
// Description : Shared constants, record layout and scheduler state encoding
//               for the Mandelbrot pass scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mandelbrot_pkg;

    localparam int H_RES  = 800;
    localparam int V_RES  = 480;
    localparam int NUM_PX = H_RES * V_RES;

    // Datapath record: {PxVal, X, Y, Iter}
    localparam int REC_W     = 104;
    localparam int PXVAL_MSB = 103;
    localparam int PXVAL_LSB = 96;
    localparam int X_MSB     = 95;
    localparam int X_LSB     = 64;
    localparam int Y_MSB     = 63;
    localparam int Y_LSB     = 32;
    localparam int ITER_MSB  = 31;
    localparam int ITER_LSB  = 0;

    localparam logic [7:0]       PX_INTERIOR = 8'hFF;
    localparam logic [REC_W-1:0] SEED_WORD   = {PX_INTERIOR, 32'h0, 32'h0, 32'h0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEED  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/mandelbrot_scheduler_if.sv
// ============================================================================
// Module      : mandelbrot_scheduler_if
// Description : Datapath FIFO and framebuffer pixel buses of the scheduler.
//               master = scheduler side, slave = FIFOs / framebuffer side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mandelbrot_scheduler_if #(
    parameter int ADDR_W = 19
) ();

    logic [mandelbrot_pkg::REC_W-1:0] o_In_Data;
    logic                             o_In_Wrreq;
    logic                             i_In_Full;
    logic [mandelbrot_pkg::REC_W-1:0] i_Out_Data;
    logic                             i_Out_Empty;
    logic                             o_Out_Rdreq;
    logic                             o_Px_Valid;
    logic [7:0]                       o_Px_Value;
    logic [ADDR_W-1:0]                o_Px_Addr;
    logic                             i_Px_Ready;

    modport master (
        output o_In_Data, o_In_Wrreq,
        input  i_In_Full,
        input  i_Out_Data, i_Out_Empty,
        output o_Out_Rdreq,
        output o_Px_Valid, o_Px_Value, o_Px_Addr,
        input  i_Px_Ready
    );

    modport slave (
        input  o_In_Data, o_In_Wrreq,
        output i_In_Full,
        output i_Out_Data, i_Out_Empty,
        input  o_Out_Rdreq,
        input  o_Px_Valid, o_Px_Value, o_Px_Addr,
        output i_Px_Ready
    );

endinterface

`default_nettype wire

// File: rtl/mandelbrot_px_out.sv
// ============================================================================
// Module      : mandelbrot_px_out
// Description : One-entry registered valid/ready pixel stage; holds its
//               contents stable while the framebuffer writer stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mandelbrot_px_out #(
    parameter int ADDR_W = 19
) (
    input  wire logic              i_Clk,
    input  wire logic              i_Rst_n,
    input  wire logic              i_Load,
    input  wire logic [7:0]        i_Value,
    input  wire logic [ADDR_W-1:0] i_Addr,
    input  wire logic              i_Ready,
    output logic                   o_Can_Load,
    output logic                   o_Valid,
    output logic [7:0]             o_Value,
    output logic [ADDR_W-1:0]      o_Addr
);

    logic              valid_q, valid_d;
    logic [7:0]        value_q, value_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;

    // A new pixel may enter in the same cycle the held one is accepted.
    assign o_Can_Load = !valid_q || i_Ready;

    always_comb begin
        valid_d = valid_q;
        value_d = value_q;
        addr_d  = addr_q;
        if (i_Load) begin
            valid_d = 1'b1;
            value_d = i_Value;
            addr_d  = i_Addr;
        end else if (i_Ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            valid_q <= 1'b0;
            value_q <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            value_q <= value_d;
            addr_q  <= addr_d;
        end
    end

    assign o_Valid = valid_q;
    assign o_Value = value_q;
    assign o_Addr  = addr_q;

endmodule

`default_nettype wire

// File: rtl/mandelbrot_scheduler.sv
// ============================================================================
// Module      : mandelbrot_scheduler
// Description : Seeds every pixel, recirculates datapath results for
//               MaxIter-1 further passes, then retires pixels to the
//               framebuffer in strict pixel-major order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mandelbrot_scheduler
    import mandelbrot_pkg::*;
#(
    parameter int H_RES  = mandelbrot_pkg::H_RES,
    parameter int V_RES  = mandelbrot_pkg::V_RES,
    parameter int ADDR_W = 19,
    parameter int ITER_W = 8
) (
    input  wire logic               i_Clk,
    input  wire logic               i_Rst_n,
    input  wire logic               i_Start,
    input  wire logic [ITER_W-1:0]  i_Max_Iter,
    output logic                    o_Busy,
    output logic                    o_Done,
    output logic [ITER_W-1:0]       o_Pass,
    mandelbrot_scheduler_if.master  bus
);

    localparam int                NPX      = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(NPX - 1);

    sched_state_t      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q,   cnt_d;
    logic [ITER_W-1:0] pass_q,  pass_d;
    logic [ITER_W-1:0] maxi_q,  maxi_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic              retire_pass;
    logic              cnt_at_last;
    logic              px_load;
    logic              px_can_load;
    logic              in_wrreq;
    logic              out_rdreq;
    logic [REC_W-1:0]  in_data;

    assign retire_pass = (pass_q == maxi_q - ITER_W'(1));
    assign cnt_at_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        maxi_d    = maxi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        in_wrreq  = 1'b0;
        in_data   = '0;
        out_rdreq = 1'b0;
        px_load   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_Start) begin
                    maxi_d  = (i_Max_Iter == '0) ? ITER_W'(1) : i_Max_Iter;
                    cnt_d   = '0;
                    pass_d  = '0;
                    busy_d  = 1'b1;
                    state_d = SEED;
                end
            end
            SEED: begin
                if (!bus.i_In_Full) begin
                    in_wrreq = 1'b1;
                    in_data  = SEED_WORD;
                    if (cnt_at_last) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            RUN: begin
                // Records pass through unmodified so the datapath's own
                // pixel counter stays aligned with the frame order.
                if (retire_pass) begin
                    if (!bus.i_Out_Empty && px_can_load) begin
                        out_rdreq = 1'b1;
                        px_load   = 1'b1;
                    end
                end else if (!bus.i_Out_Empty && !bus.i_In_Full) begin
                    out_rdreq = 1'b1;
                    in_wrreq  = 1'b1;
                    in_data   = bus.i_Out_Data;
                end
                if (out_rdreq) begin
                    if (cnt_at_last) begin
                        cnt_d = '0;
                        if (retire_pass) begin
                            state_d = FLUSH;
                        end else begin
                            pass_d = pass_q + ITER_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (px_can_load) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pass_q  <= '0;
            maxi_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            maxi_q  <= maxi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    mandelbrot_px_out #(
        .ADDR_W (ADDR_W)
    ) u_px_out (
        .i_Clk      (i_Clk),
        .i_Rst_n    (i_Rst_n),
        .i_Load     (px_load),
        .i_Value    (bus.i_Out_Data[PXVAL_MSB:PXVAL_LSB]),
        .i_Addr     (cnt_q),
        .i_Ready    (bus.i_Px_Ready),
        .o_Can_Load (px_can_load),
        .o_Valid    (bus.o_Px_Valid),
        .o_Value    (bus.o_Px_Value),
        .o_Addr     (bus.o_Px_Addr)
    );

    assign bus.o_In_Data   = in_data;
    assign bus.o_In_Wrreq  = in_wrreq;
    assign bus.o_Out_Rdreq = out_rdreq;
    assign o_Busy          = busy_q;
    assign o_Done          = done_q;
    assign o_Pass          = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_mandelbrot_scheduler.sv
// ============================================================================
// Module      : tb_mandelbrot_scheduler
// Description : Scheduler bench on a 4x2 frame with a loopback datapath
//               (pixel p escapes after p+1 iterations) and 16-deep FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mandelbrot_scheduler;
    import mandelbrot_pkg::*;

    localparam int TB_H  = 4;
    localparam int TB_V  = 2;
    localparam int TB_NPX = TB_H * TB_V;
    localparam int TB_AW = 3;
    localparam int TB_IW = 8;
    localparam int DEPTH = 16;

    typedef logic [7:0] vec8_t [8];
    localparam vec8_t EXP_M1 = '{8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    localparam vec8_t EXP_M2 = '{8'h01, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    localparam vec8_t EXP_M3 = '{8'h01, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    localparam vec8_t EXP_M5 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFF, 8'hFF, 8'hFF};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [TB_IW-1:0] max_iter = '0;
    logic             busy;
    logic             done;
    logic [TB_IW-1:0] pass_o;
    logic             px_ready = 1'b1;
    logic             toggle_ready = 1'b0;
    logic             force_full = 1'b0;

    mandelbrot_scheduler_if #(.ADDR_W(TB_AW)) bus ();

    mandelbrot_scheduler #(
        .H_RES  (TB_H),
        .V_RES  (TB_V),
        .ADDR_W (TB_AW),
        .ITER_W (TB_IW)
    ) dut (
        .i_Clk      (clk),
        .i_Rst_n    (rst_n),
        .i_Start    (start),
        .i_Max_Iter (max_iter),
        .o_Busy     (busy),
        .o_Done     (done),
        .o_Pass     (pass_o),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- FIFOs + loopback datapath ----------------
    logic [REC_W-1:0] in_q[$];
    logic [REC_W-1:0] out_q[$];
    logic             in_full_m = 1'b0;
    logic             out_empty_m = 1'b1;
    logic [REC_W-1:0] out_head = '0;
    int               dp_pix = 0;
    int               seeds_total = 0;
    int               recirc_total = 0;

    function automatic logic [REC_W-1:0] dp_step(input logic [REC_W-1:0] r, input int pix);
        logic [31:0] it;
        logic [7:0]  pv;
        it = r[31:0] + 32'd1;
        pv = r[103:96];
        if (pv == 8'hFF && it == 32'(pix + 1)) pv = it[7:0];
        return {pv, 32'(pix), 32'h0, it};
    endfunction

    assign bus.i_In_Full   = in_full_m | force_full;
    assign bus.i_Out_Empty = out_empty_m;
    assign bus.i_Out_Data  = out_head;
    assign bus.i_Px_Ready  = px_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q.delete();
            out_q.delete();
            in_full_m   <= 1'b0;
            out_empty_m <= 1'b1;
            out_head    <= '0;
            dp_pix      <= 0;
        end else begin
            if (bus.o_Out_Rdreq && out_q.size() > 0) void'(out_q.pop_front());
            if (in_q.size() > 0 && out_q.size() < DEPTH) begin
                out_q.push_back(dp_step(in_q[0], dp_pix));
                void'(in_q.pop_front());
                dp_pix <= (dp_pix + 1) % TB_NPX;
            end
            if (bus.o_In_Wrreq) begin
                in_q.push_back(bus.o_In_Data);
                if (bus.o_Out_Rdreq) recirc_total <= recirc_total + 1;
                else                 seeds_total  <= seeds_total + 1;
            end
            in_full_m   <= (in_q.size() >= DEPTH);
            out_empty_m <= (out_q.size() == 0);
            out_head    <= (out_q.size() > 0) ? out_q[0] : '0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    logic [TB_AW+7:0] exp_q[$];
    logic             hold_pend = 1'b0;
    logic [7:0]       hold_val = '0;
    logic [TB_AW-1:0] hold_addr = '0;
    logic [TB_IW-1:0] prev_pass = '0;
    logic             prev_busy = 1'b0;
    int               px_total = 0;
    int               pass_steps = 0;
    int               last_acc_cyc = -10;
    int               done_cyc = -20;
    logic [TB_IW-1:0] pass_at_done = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend <= 1'b0;
            prev_busy <= 1'b0;
        end else begin
            if (bus.o_In_Wrreq)  check("wr_while_full", bus.i_In_Full, 1'b0);
            if (bus.o_Out_Rdreq) check("rd_while_empty", bus.i_Out_Empty, 1'b0);
            if (bus.o_In_Wrreq && !bus.o_Out_Rdreq) check("seed_word", bus.o_In_Data, SEED_WORD);
            if (hold_pend) begin
                check("px_hold_valid", bus.o_Px_Valid, 1'b1);
                check("px_hold_data", {bus.o_Px_Value, bus.o_Px_Addr}, {hold_val, hold_addr});
            end
            if (bus.o_Px_Valid && bus.i_Px_Ready) begin
                if (exp_q.size() == 0) begin
                    check("px_unexpected", 1'b1, 1'b0);
                end else begin
                    check("px_addr", bus.o_Px_Addr, exp_q[0][TB_AW+7:8]);
                    check("px_value", bus.o_Px_Value, exp_q[0][7:0]);
                    void'(exp_q.pop_front());
                end
                px_total     <= px_total + 1;
                last_acc_cyc <= cyc;
            end
            hold_pend <= bus.o_Px_Valid && !bus.i_Px_Ready;
            hold_val  <= bus.o_Px_Value;
            hold_addr <= bus.o_Px_Addr;
            if (busy && prev_busy && pass_o != prev_pass) begin
                check("pass_step", pass_o, prev_pass + 8'd1);
                pass_steps <= pass_steps + 1;
            end
            prev_pass <= pass_o;
            prev_busy <= busy;
            if (done) begin
                done_cyc     <= cyc;
                pass_at_done <= pass_o;
            end
        end
    end

    // ---------------- ready pattern ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            px_ready = toggle_ready ? ~px_ready : 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    int base_seeds, base_recirc, base_px, base_steps;

    task automatic launch(input logic [TB_IW-1:0] m, input vec8_t expv);
        for (int i = 0; i < TB_NPX; i++) exp_q.push_back({TB_AW'(i), expv[i]});
        base_seeds  = seeds_total;
        base_recirc = recirc_total;
        base_px     = px_total;
        base_steps  = pass_steps;
        @(posedge clk); #1;
        start    = 1'b1;
        max_iter = m;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int exp_recirc, input int exp_pass);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check({tag, "_done_timeout"}, got, 1'b1);
        @(negedge clk);
        check({tag, "_seeds"},      32'(seeds_total - base_seeds), 32'd8);
        check({tag, "_recirc"},     32'(recirc_total - base_recirc), 32'(exp_recirc));
        check({tag, "_pixels"},     32'(px_total - base_px), 32'd8);
        check({tag, "_sb_empty"},   32'(exp_q.size()), 32'd0);
        check({tag, "_done_lat"},   32'(done_cyc - last_acc_cyc), 32'd1);
        check({tag, "_pass_final"}, pass_at_done, 8'(exp_pass));
        check({tag, "_pass_steps"}, 32'(pass_steps - base_steps), 32'(exp_pass));
        check({tag, "_busy_clear"}, busy, 1'b0);
    endtask

    task automatic wait_pass(input logic [TB_IW-1:0] p);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (pass_o == p) got = 1'b1;
        end
        check("pass_reach_timeout", got, 1'b1);
    endtask

    initial begin
        int s0;
        logic got;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",   busy, 1'b0);
        check("rst_done",   done, 1'b0);
        check("rst_pass",   pass_o, '0);
        check("rst_wrreq",  bus.o_In_Wrreq, 1'b0);
        check("rst_rdreq",  bus.o_Out_Rdreq, 1'b0);
        check("rst_pxv",    bus.o_Px_Valid, 1'b0);
        check("rst_pxval",  bus.o_Px_Value, '0);
        check("rst_pxaddr", bus.o_Px_Addr, '0);
        check("rst_indata", bus.o_In_Data, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single pass: seed then retire directly
        launch(8'd1, EXP_M1);
        finish_frame("m1", 0, 0);

        // five passes; i_Max_Iter changes mid-frame are ignored
        launch(8'd5, EXP_M5);
        max_iter = 8'd2;
        finish_frame("m5", 32, 4);

        // writer backpressure on alternate cycles
        toggle_ready = 1'b1;
        launch(8'd3, EXP_M3);
        finish_frame("m3_bp", 16, 2);
        toggle_ready = 1'b0;

        // input FIFO stalled for 10 cycles mid-SEED
        launch(8'd2, EXP_M2);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #1;
            if (seeds_total - base_seeds >= 3) got = 1'b1;
        end
        check("stall_arm_timeout", got, 1'b1);
        force_full = 1'b1;
        s0 = seeds_total;
        repeat (10) begin
            @(negedge clk);
            check("stall_wrreq", bus.o_In_Wrreq, 1'b0);
        end
        check("stall_cnt_frozen", 32'(seeds_total - s0), 32'd0);
        @(posedge clk); #1;
        force_full = 1'b0;
        finish_frame("m2_stall", 8, 1);

        // start during RUN ignored, then reset mid-RUN at pass 2
        launch(8'd4, EXP_M1);
        wait_pass(8'd1);
        @(posedge clk); #1;
        start    = 1'b1;
        max_iter = 8'd1;
        @(posedge clk); #1;
        start    = 1'b0;
        wait_pass(8'd2);
        check("ign_start_seeds", 32'(seeds_total - base_seeds), 32'd8);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_busy",  busy, 1'b0);
        check("arst_pass",  pass_o, '0);
        check("arst_wrreq", bus.o_In_Wrreq, 1'b0);
        check("arst_rdreq", bus.o_Out_Rdreq, 1'b0);
        check("arst_pxv",   bus.o_Px_Valid, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // i_Max_Iter=0 behaves as a single pass
        launch(8'd0, EXP_M1);
        finish_frame("m0", 0, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mandelbrot_scheduler.md
Name: mandelbrot_scheduler

Overview:
- Sequences the iteration datapath over full-frame passes.
- Seeds every pixel once, then recirculates datapath results back into the datapath input FIFO for MaxIter-1 further passes.
- On the final pass, retires each record's 8-bit pixel value with its frame address to the framebuffer writer.
- Sits between the datapath's input/output FIFOs and the framebuffer write port. Preserves strict pixel-major order so the datapath's internal cx/cy counter stays aligned.

Parameters:
- H_RES, 800, pixels per line
- V_RES, 480, lines per frame
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W ≥ H_RES*V_RES
- ITER_W, 8, width of max-iteration and pass counters

Ports:
- i_Clk  in  1  clock
- i_Rst_n  in  1  asynchronous active-low reset
- i_Start  in  1  one-cycle start pulse; ignored while o_Busy=1
- i_Max_Iter  in  ITER_W  number of passes; sampled on accepted i_Start
- o_Busy  out  1  high from accepted start until o_Done
- o_Done  out  1  one-cycle pulse when the frame is complete
- o_Pass  out  ITER_W  current pass index
- o_In_Data  out  104  record to datapath input FIFO: {PxVal[103:96], X[95:64], Y[63:32], Iter[31:0]}
- o_In_Wrreq  out  1  input FIFO write strobe
- i_In_Full  in  1  input FIFO full
- i_Out_Data  in  104  show-ahead head of datapath output FIFO
- i_Out_Empty  in  1  output FIFO empty
- o_Out_Rdreq  out  1  output FIFO read acknowledge
- o_Px_Valid  out  1  retired pixel valid
- o_Px_Value  out  8  pixel value; 8'hFF = interior (never escaped)
- o_Px_Addr  out  ADDR_W  linear address cy*H_RES+cx
- i_Px_Ready  in  1  framebuffer writer accepts

Behaviour:
- NUM_PX = H_RES*V_RES. Record counter cnt runs 0..NUM_PX-1.
- Reset values: all outputs 0; state IDLE; cnt=0; pass=0. Reset mid-frame aborts immediately. External FIFOs share the same reset.
- States:
  - IDLE: on i_Start, latch maxi = (i_Max_Iter==0) ? 1 : i_Max_Iter; clear cnt and pass; go to SEED; o_Busy=1 from the next cycle.
  - SEED: when !i_In_Full, o_In_Wrreq=1 combinationally with o_In_Data = SEED_WORD {8'hFF,32'h0,32'h0,32'h0}; cnt++. The write at cnt==NUM_PX-1 sets cnt=0 and goes to RUN (pass stays 0). o_Out_Rdreq=0 throughout SEED.
  - RUN, pass < maxi-1 (recirculate): transfer when !i_Out_Empty && !i_In_Full. In that same cycle o_Out_Rdreq=1, o_In_Wrreq=1, o_In_Data=i_Out_Data unmodified; cnt++.
  - RUN, pass == maxi-1 (retire): transfer when !i_Out_Empty && (!o_Px_Valid || i_Px_Ready). On transfer o_Out_Rdreq=1 and, next cycle, o_Px_Valid=1, o_Px_Value=i_Out_Data[103:96], o_Px_Addr=cnt; cnt++. o_In_Wrreq=0 during retire.
  - Pass end (RUN): on the transfer at cnt==NUM_PX-1, cnt wraps to 0. If pass < maxi-1, pass++; otherwise go to FLUSH.
  - FLUSH: hold until o_Px_Valid==0 or i_Px_Ready. Then drop o_Px_Valid, pulse o_Done, clear o_Busy, go to IDLE.
- Pixel output: o_Px_Valid/Value/Addr form a registered one-entry stage. They hold stable while o_Px_Valid && !i_Px_Ready; no drop, no duplicate.
- maxi==1: SEED, then one retire pass; no recirculation.
- o_Out_Rdreq and o_In_Wrreq are never asserted when the corresponding empty/full is set.
- System requirement, not checked by this block: loop capacity (input FIFO + output FIFO + datapath) ≥ NUM_PX records, since a full pass is buffered before recirculation begins.
- i_Start while busy: ignored, no side effect. i_Max_Iter changes mid-frame: no effect.

Decomposition:
- Package mandelbrot_pkg holds: H_RES, V_RES, NUM_PX; record field offsets (PXVAL/X/Y/ITER msb/lsb); SEED_WORD; PX_INTERIOR=8'hFF; state enum {IDLE, SEED, RUN, FLUSH}.
- One sub-module: mandelbrot_px_out, the registered valid/ready pixel stage with hold-under-backpressure.

Test Plan:
- Benches use H_RES=4, V_RES=2 (NUM_PX=8), a loopback datapath model (Iter+1, PxVal=Iter at escape) and 16-deep FIFOs.
- Reset mid-RUN at pass 2 -> next cycle all outputs 0, o_Busy=0; new i_Start begins with 8 SEED_WORD writes.
- i_Max_Iter=1 -> exactly 8 seeds; 8 pixels with addresses 0..7 in order; 0 recirculations; o_Done one cycle after the last pixel is accepted.
- i_Max_Iter=5, i_Px_Ready=1 -> 8 seeds, 32 recirculated writes; o_Pass steps 0..4; 8 pixels retired with correct PxVal.
- i_Px_Ready toggled 1/0 every other cycle during retire -> each of addresses 0..7 appears exactly once, held stable while stalled.
- i_In_Full forced high for 10 cycles mid-SEED -> o_In_Wrreq=0 during the stall; cnt frozen; completes with exactly 8 seeds.
- i_Start pulsed during RUN; i_Max_Iter=0 on a later start -> first start ignored; second behaves as maxi=1.
